// File: rtl/param_pipeline.sv
// param_pipeline: in-order tag pipeline with global hold, per-stage
// hazard stall with bubble insertion, per-stage flush and retire count.
module param_pipeline #(
  parameter int STAGES  = 5,
  parameter int STATE_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      stall,
  input  logic [STAGES-1:0]         stall_stage,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES*STATE_W-1:0] state_flat,
  output logic [STAGES-1:0]         valid_flat,
  output logic [STATE_W-1:0]        next_state,
  output logic                      retire,
  output logic [15:0]               retire_count
);

  localparam logic [STATE_W-1:0] ONE = STATE_W'(1);

  typedef logic [STAGES-1:0][STATE_W-1:0] tags_t;

  tags_t              tag_q;
  tags_t              tag_d;
  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  valid_d;
  logic [STAGES-1:0]  any_ge;
  logic [STATE_W-1:0] cnt_q;
  logic               hold;
  logic               acc;
  logic               issue;
  logic               tail_adv;
  logic               do_retire;

  assign hold      = !en || stall;
  assign issue     = !hold && !any_ge[0];
  assign tail_adv  = !hold && !stall_stage[STAGES-1];
  assign do_retire = tail_adv && valid_q[STAGES-1];

  always_comb begin
    acc     = 1'b0;
    any_ge  = '0;
    tag_d   = tag_q;
    valid_d = valid_q;
    // any_ge[k]: some stage at or above k requests a stall, so k holds
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc       = acc | stall_stage[i];
      any_ge[i] = acc;
    end
    if (issue) begin
      tag_d[0]   = cnt_q;
      valid_d[0] = 1'b1;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (!hold && !any_ge[k]) begin
        if (stall_stage[k-1]) begin
          tag_d[k]   = '0;
          valid_d[k] = 1'b0;
        end else begin
          tag_d[k]   = tag_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
    end
    valid_d = valid_d & ~flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q        <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      retire       <= 1'b0;
      retire_count <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      retire  <= do_retire;
      if (issue) begin
        cnt_q <= cnt_q + ONE;
      end
      if (do_retire && retire_count != 16'hFFFF) begin
        retire_count <= retire_count + 16'd1;
      end
    end
  end

  assign state_flat = tag_q;
  assign valid_flat = valid_q;
  assign next_state = cnt_q;

endmodule

// File: tb/tb_param_pipeline.sv
// tb_param_pipeline: directed vector table, hand sequences and random
// traffic checked against an entry-level pipeline reference model.
module tb_param_pipeline;

  localparam int S = 5;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           stall = 1'b0;
  logic [S-1:0]   stall_stage = '0;
  logic [S-1:0]   flush = '0;
  logic [S*W-1:0] state_flat;
  logic [S-1:0]   valid_flat;
  logic [W-1:0]   next_state;
  logic           retire;
  logic [15:0]    retire_count;

  param_pipeline #(.STAGES(S), .STATE_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall),
    .stall_stage(stall_stage), .flush(flush),
    .state_flat(state_flat), .valid_flat(valid_flat),
    .next_state(next_state), .retire(retire),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one record per stage, issue counter, retire state
  logic [W-1:0] m_tag [S];
  bit           m_vld [S];
  int           m_cnt;
  bit           m_ret;
  int           m_rc;

  typedef struct {
    logic         en;
    logic         stall;
    logic [S-1:0] ss;
    logic [S-1:0] fl;
    logic [S*W-1:0] tags;
    logic [S-1:0] vld;
    logic [W-1:0] nxt;
    logic         ret;
    logic [15:0]  cnt;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [S*W-1:0] pk(input int a, b, c, d, e);
    logic [W-1:0] t0, t1, t2, t3, t4;
    t0 = W'(a); t1 = W'(b); t2 = W'(c); t3 = W'(d); t4 = W'(e);
    return {t4, t3, t2, t1, t0};
  endfunction

  function automatic vec_t mk(input logic e, st, input logic [S-1:0] ss,
                              fl, input logic [S*W-1:0] tg,
                              input logic [S-1:0] v, input int nx,
                              input logic r, input int c);
    vec_t x;
    x.en = e; x.stall = st; x.ss = ss; x.fl = fl; x.tags = tg;
    x.vld = v; x.nxt = W'(nx); x.ret = r; x.cnt = 16'(c);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < S; k++) begin
      m_tag[k] = '0;
      m_vld[k] = 0;
    end
    m_cnt = 0; m_ret = 0; m_rc = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] ot [S];
    bit           ov [S];
    int           h;
    for (int k = 0; k < S; k++) begin
      ot[k] = m_tag[k];
      ov[k] = m_vld[k];
    end
    if (!en || stall) begin
      m_ret = 0;
    end else begin
      h = -1;
      for (int k = 0; k < S; k++) if (stall_stage[k]) h = k;
      for (int k = 0; k < S; k++) begin
        if (k <= h) begin
        end else if (h >= 0 && k == h + 1) begin
          m_tag[k] = '0; m_vld[k] = 0;
        end else if (k == 0) begin
          m_tag[0] = W'(m_cnt); m_vld[0] = 1;
        end else begin
          m_tag[k] = ot[k-1]; m_vld[k] = ov[k-1];
        end
      end
      m_ret = (h < S - 1) && ov[S-1];
      if (m_ret && m_rc < 65535) m_rc++;
      if (h == -1) m_cnt = (m_cnt + 1) % (1 << W);
    end
    for (int k = 0; k < S; k++) if (flush[k]) m_vld[k] = 0;
  endtask

  task automatic check_model(input string ctx);
    logic [S*W-1:0] ft;
    logic [S-1:0]   fv;
    for (int k = 0; k < S; k++) begin
      ft[k*W +: W] = m_tag[k];
      fv[k] = m_vld[k];
    end
    chk({ctx, ".tags"}, 32'(state_flat), 32'(ft));
    chk({ctx, ".valid"}, 32'(valid_flat), 32'(fv));
    chk({ctx, ".next"}, 32'(next_state), 32'(m_cnt));
    chk({ctx, ".retire"}, 32'(retire), 32'(m_ret));
    chk({ctx, ".count"}, 32'(retire_count), 32'(m_rc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic e, st, input logic [S-1:0] ss, fl);
    en = e; stall = st; stall_stage = ss; flush = fl;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, pk(0,0,0,0,0), 5'b00001, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, pk(1,0,0,0,0), 5'b00011, 2, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, pk(2,1,0,0,0), 5'b00111, 3, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, pk(3,2,1,0,0), 5'b01111, 4, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, pk(4,3,2,1,0), 5'b11111, 5, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, pk(4,3,2,1,0), 5'b11111, 5, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, pk(4,3,2,1,0), 5'b11111, 5, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, pk(4,3,2,1,0), 5'b11111, 5, 0, 0);
    tbl[8]  = mk(1, 0, 5'b00100, 0, pk(4,3,2,0,1), 5'b10111, 5, 1, 1);
    tbl[9]  = mk(1, 0, 0, 0, pk(5,4,3,2,0), 5'b01111, 6, 1, 2);
    tbl[10] = mk(1, 0, 0, 0, pk(6,5,4,3,2), 5'b11111, 7, 0, 2);
    tbl[11] = mk(0, 0, 0, 0, pk(6,5,4,3,2), 5'b11111, 7, 0, 2);
    tbl[12] = mk(1, 0, 0, 0, pk(7,6,5,4,3), 5'b11111, 0, 1, 3);
    tbl[13] = mk(1, 0, 0, 0, pk(0,7,6,5,4), 5'b11111, 1, 1, 4);

    model_reset();
    #10;
    chk("rst.tags", 32'(state_flat), 0);
    chk("rst.valid", 32'(valid_flat), 0);
    chk("rst.next", 32'(next_state), 0);
    chk("rst.retire", 32'(retire), 0);
    chk("rst.count", 32'(retire_count), 0);
    #10 rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].stall, tbl[i].ss, tbl[i].fl);
      tick();
      chk($sformatf("vec%0d.tags", i), 32'(state_flat), 32'(tbl[i].tags));
      chk($sformatf("vec%0d.valid", i), 32'(valid_flat), 32'(tbl[i].vld));
      chk($sformatf("vec%0d.next", i), 32'(next_state), 32'(tbl[i].nxt));
      chk($sformatf("vec%0d.retire", i), 32'(retire), 32'(tbl[i].ret));
      chk($sformatf("vec%0d.count", i), 32'(retire_count), 32'(tbl[i].cnt));
    end

    // flush of stalled front stages: entries become invalid, never retire
    drive(1, 0, 5'b00111, 5'b00111);
    tick();
    chk("flush.low_valid", 32'(valid_flat[2:0]), 0);
    check_model("flush");
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_model($sformatf("drain%0d", i));
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, '0, '0);
      for (int k = 0; k < S; k++) begin
        stall_stage[k] = $urandom_range(0, 7) == 0;
        flush[k] = $urandom_range(0, 15) == 0;
      end
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    // asynchronous reset between edges, then refill from tag 0
    drive(1, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst.tags", 32'(state_flat), 0);
    chk("mid_rst.valid", 32'(valid_flat), 0);
    chk("mid_rst.next", 32'(next_state), 0);
    chk("mid_rst.retire", 32'(retire), 0);
    chk("mid_rst.count", 32'(retire_count), 0);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_model($sformatf("refill%0d", i));
    end
    chk("refill.retire6", 32'(retire), 1);
    chk("refill.count6", 32'(retire_count), 1);
    chk("refill.tail_tag", 32'(state_flat[4*W +: W]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
